// File: rtl/machine_pkg.sv
// rtl/machine_pkg.sv - shared types and widths for the input conditioner and control automaton
// Contents: state_t (IDLE/WAIT/RUN run-handshake states), ON_W (mode code width).
package machine_pkg;

    localparam int ON_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - synchroniser plus debouncer for one asynchronous input bit
// Ports: clk (rising edge), rst (async, active-low), raw (asynchronous input),
//        stable (debounced value, registered).
module debounce_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   sync_bit;

    assign sync_bit = sync_q[SYNC_STAGES-1];
    assign stable   = stable_q;

    // The counter only survives while the synchronised value keeps disagreeing;
    // the flip happens on the edge where it would reach DEBOUNCE_CYCLES.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync_bit != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_bit;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], raw};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - debounced mode/start front end with busy handshake to the control automaton
// Ports: clk, rst (async, active-low), on_raw[1:0], start_raw, active (automaton busy),
//        on[1:0] (clean mode code), start (1-cycle pulse), rejected (1-cycle pulse).
// Optional: define START_QUEUE_EN to hold one press made while busy and launch it on return to IDLE.
module input_conditioner
    import machine_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SYNC_STAGES     = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ON_W-1:0] on_raw,
    input  logic            start_raw,
    input  logic            active,
    output logic [ON_W-1:0] on,
    output logic            start,
    output logic            rejected
);

    logic [ON_W-1:0] on_stable;
    logic            start_stable;
    logic            start_prev_q;
    logic            start_req;
    logic            launch;

    state_t          state_q, state_d;
    logic [ON_W-1:0] frozen_q, frozen_d;
    logic            start_q, start_d;
    logic            rejected_q, rejected_d;
`ifdef START_QUEUE_EN
    logic            pending_q, pending_d;
`endif

    for (genvar g = 0; g < ON_W; g++) begin : g_on_db
        debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .raw    (on_raw[g]),
            .stable (on_stable[g])
        );
    end

    debounce_bit #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_start_db (
        .clk    (clk),
        .rst    (rst),
        .raw    (start_raw),
        .stable (start_stable)
    );

    // Press edge only; the release edge is ignored.
    assign start_req = start_stable & ~start_prev_q;

    // Both mux legs are registers: in IDLE the debounced switches pass through,
    // otherwise the value latched at launch is held.
    assign on       = (state_q == IDLE) ? on_stable : frozen_q;
    assign start    = start_q;
    assign rejected = rejected_q;

    always_comb begin
        state_d    = state_q;
        frozen_d   = frozen_q;
        start_d    = 1'b0;
        rejected_d = 1'b0;
        launch     = 1'b0;
`ifdef START_QUEUE_EN
        pending_d  = pending_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef START_QUEUE_EN
                if (!active && (start_req || pending_q)) begin
                    launch    = 1'b1;
                    // A fresh press coinciding with a queued launch stays queued.
                    pending_d = start_req && pending_q;
                end else if (start_req) begin
                    rejected_d = 1'b1;
                end
`else
                if (start_req) begin
                    if (active) begin
                        rejected_d = 1'b1;
                    end else begin
                        launch = 1'b1;
                    end
                end
`endif
            end
            WAIT: begin
                if (active) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!active) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Presses while a run is in flight, including the cycle active drops.
        if (state_q != IDLE && start_req) begin
`ifdef START_QUEUE_EN
            if (pending_q) begin
                rejected_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
`else
            rejected_d = 1'b1;
`endif
        end

        if (launch) begin
            start_d  = 1'b1;
            frozen_d = on_stable;
            state_d  = WAIT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            frozen_q     <= '0;
            start_q      <= 1'b0;
            rejected_q   <= 1'b0;
            start_prev_q <= 1'b0;
`ifdef START_QUEUE_EN
            pending_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            frozen_q     <= frozen_d;
            start_q      <= start_d;
            rejected_q   <= rejected_d;
            start_prev_q <= start_stable;
`ifdef START_QUEUE_EN
            pending_q    <= pending_d;
`endif
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - scoreboard bench for input_conditioner with window-based reference model
module tb_input_conditioner;

    localparam int S    = 2;
    localparam int D    = 4;
    localparam int MAXC = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] on_raw = 2'b00;
    logic       start_raw = 1'b0;
    logic       active = 1'b0;
    logic [1:0] on;
    logic       start;
    logic       rejected;

    always #5 clk = ~clk;

    input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .SYNC_STAGES     (S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .on_raw    (on_raw),
        .start_raw (start_raw),
        .active    (active),
        .on        (on),
        .start     (start),
        .rejected  (rejected)
    );

    typedef struct {
        int c;
        bit is_start;
    } ev_t;

    ev_t      evq[$];
    int       tests = 0;
    int       fails = 0;
    int       cyc = 0;
    bit       mon_en = 1'b0;
    bit [1:0] exp_on = 2'b00;

    // raw_h[k]: {start,on} sampled at edge k; stab_h[n]: debounced value after edge n
    bit [2:0] raw_h [MAXC];
    bit [2:0] stab_h[MAXC];

    bit       m_busy;
    bit       m_seen_act;
    bit [1:0] m_frozen;
`ifdef START_QUEUE_EN
    bit       m_pending;
`endif
    int       run_start;
    int       run_end;
    int       run_len = 5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic bit [2:0] get_raw(input int k);
        if (k < 1) return 3'b000;
        return raw_h[k];
    endfunction

    function automatic bit [2:0] get_stab(input int n);
        if (n < 1) return 3'b000;
        return stab_h[n];
    endfunction

    task automatic reset_model();
        cyc = 0;
        for (int i = 0; i < MAXC; i++) begin
            raw_h[i]  = 3'b000;
            stab_h[i] = 3'b000;
        end
        m_busy     = 1'b0;
        m_seen_act = 1'b0;
        m_frozen   = 2'b00;
`ifdef START_QUEUE_EN
        m_pending  = 1'b0;
`endif
        run_start  = -10;
        run_end    = -20;
        exp_on     = 2'b00;
        evq.delete();
    endtask

    // A bit's debounced value after edge n is v when its last D synchronised
    // samples (raw samples n-S-D+1 .. n-S) all equal v; otherwise it is unchanged.
    task automatic model_step(input int n, input bit a);
        bit  req;
        bit  go;
        bit  all_eq;
        bit  v;
        ev_t e;
        for (int b = 0; b < 3; b++) begin
            v      = get_raw(n - S)[b];
            all_eq = 1'b1;
            for (int k = n - S - D + 1; k <= n - S; k++) begin
                if (get_raw(k)[b] != v) all_eq = 1'b0;
            end
            stab_h[n][b] = all_eq ? v : get_stab(n - 1)[b];
        end
        req = get_stab(n - 1)[2] && !get_stab(n - 2)[2];
        go  = 1'b0;
        if (!m_busy) begin
`ifdef START_QUEUE_EN
            if (!a && (req || m_pending)) begin
                go        = 1'b1;
                m_pending = req && m_pending;
            end else if (req) begin
                e.c = n; e.is_start = 1'b0; evq.push_back(e);
            end
`else
            if (req) begin
                if (a) begin
                    e.c = n; e.is_start = 1'b0; evq.push_back(e);
                end else begin
                    go = 1'b1;
                end
            end
`endif
            if (go) begin
                e.c = n; e.is_start = 1'b1; evq.push_back(e);
                m_busy     = 1'b1;
                m_seen_act = 1'b0;
                m_frozen   = get_stab(n - 1)[1:0];
                run_start  = n + 2;
                run_end    = n + 1 + run_len;
            end
        end else begin
            if (req) begin
`ifdef START_QUEUE_EN
                if (m_pending) begin
                    e.c = n; e.is_start = 1'b0; evq.push_back(e);
                end else begin
                    m_pending = 1'b1;
                end
`else
                e.c = n; e.is_start = 1'b0; evq.push_back(e);
`endif
            end
            if (!m_seen_act) begin
                if (a) m_seen_act = 1'b1;
            end else if (!a) begin
                m_busy = 1'b0;
            end
        end
        exp_on = m_busy ? m_frozen : stab_h[n][1:0];
    endtask

    task automatic do_cycle(input logic [1:0] onr, input logic str, input bit fa);
        int nxt;
        bit a;
        nxt = cyc + 1;
        a   = fa || (nxt >= run_start && nxt <= run_end);
        on_raw    = onr;
        start_raw = str;
        active    = a;
        raw_h[nxt] = {str, onr};
        @(posedge clk);
        cyc = nxt;
        model_step(nxt, a);
        #1;
    endtask

    task automatic run_cycles(input int n, input logic [1:0] onr, input logic str, input bit fa);
        repeat (n) do_cycle(onr, str, fa);
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        if (mon_en && rst && cyc > 0) begin
            check("on_code", on, exp_on);
            if (start && rejected) check("start_rej_exclusive", 1, 0);
            while (evq.size() > 0 && evq[0].c < cyc) begin
                e = evq.pop_front();
                check(e.is_start ? "missed_start" : "missed_rejected", 0, 1);
            end
            if (start || rejected) begin
                if (evq.size() == 0) begin
                    check(start ? "unexpected_start" : "unexpected_rejected", 1, 0);
                end else begin
                    e = evq.pop_front();
                    check("event_kind_is_start", start, e.is_start);
                    check("event_cycle", cyc, e.c);
                end
            end
        end
    end

    initial begin : stim
        int       hold;
        int       fa_left;
        logic     str;
        logic [1:0] onr;

        reset_model();
        on_raw = 2'b10;
        repeat (3) @(posedge clk);
        #1;
        check("reset_on", on, 2'b00);
        check("reset_start", start, 1'b0);
        check("reset_rejected", rejected, 1'b0);
        rst = 1'b1;
        mon_en = 1'b1;

        run_cycles(5, 2'b10, 1'b0, 1'b0);
        check("on_before_edge6", on, 2'b00);
        run_cycles(1, 2'b10, 1'b0, 1'b0);
        check("on_at_edge6", on, 2'b10);
        run_cycles(10, 2'b10, 1'b0, 1'b0);

        // glitch shorter than D, then a valid 10-cycle press
        run_cycles(3, 2'b10, 1'b1, 1'b0);
        run_cycles(12, 2'b10, 1'b0, 1'b0);
        run_len = 5;
        run_cycles(10, 2'b10, 1'b1, 1'b0);
        run_cycles(20, 2'b10, 1'b0, 1'b0);

        // handshake, freeze, busy press during RUN
        run_len = 20;
        run_cycles(8, 2'b01, 1'b0, 1'b0);
        run_cycles(8, 2'b01, 1'b1, 1'b0);
        run_cycles(6, 2'b01, 1'b0, 1'b0);
        run_cycles(8, 2'b11, 1'b0, 1'b0);
        run_cycles(6, 2'b11, 1'b1, 1'b0);
        run_cycles(25, 2'b11, 1'b0, 1'b0);

        // press while IDLE but active held high
        run_cycles(10, 2'b11, 1'b1, 1'b1);
        run_cycles(10, 2'b11, 1'b0, 1'b0);

        // async reset in the middle of a run
        run_len = 30;
        run_cycles(8, 2'b01, 1'b0, 1'b0);
        run_cycles(8, 2'b01, 1'b1, 1'b0);
        run_cycles(10, 2'b01, 1'b0, 1'b0);
        check("frozen_before_reset", on, 2'b01);
        #3;
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        check("async_reset_on", on, 2'b00);
        check("async_reset_start", start, 1'b0);
        check("async_reset_rejected", rejected, 1'b0);
        reset_model();
        active = 1'b0;
        start_raw = 1'b0;
        on_raw = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b1;
        run_len = 6;
        run_cycles(6, 2'b00, 1'b1, 1'b0);
        check("fresh_press_no_start_e6", start, 1'b0);
        run_cycles(1, 2'b00, 1'b1, 1'b0);
        check("fresh_press_start_e7", start, 1'b1);
        run_cycles(3, 2'b00, 1'b1, 1'b0);
        run_cycles(20, 2'b00, 1'b0, 1'b0);

        // randomized phase
        str = 1'b0;
        onr = 2'b00;
        hold = 0;
        fa_left = 0;
        repeat (2500) begin
            if ($urandom_range(0, 39) == 0) onr = 2'($urandom_range(0, 3));
            if (hold == 0) begin
                str  = ~str;
                hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 14);
            end
            hold--;
            if (fa_left == 0 && $urandom_range(0, 99) == 0) fa_left = $urandom_range(1, 6);
            run_len = $urandom_range(3, 25);
            do_cycle(onr, str, fa_left > 0);
            if (fa_left > 0) fa_left--;
        end
        run_len = 5;
        run_cycles(60, onr, 1'b0, 1'b0);
        @(negedge clk);
        check("scoreboard_drained", evq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
